// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths and the default data-memory size for the
// VLIW memory stage.
package mem_stage_pkg;
   localparam int REG_IDX_W           = 3;
   localparam int DATA_W              = 32;
   localparam int BYTE_W              = 8;
   localparam int DEF_DMEM_ADDR_BITS  = 8;
endpackage : mem_stage_pkg

// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM bundle in (p3_*), MEM/WB bundle out (p4_*) and the
// fault flag. master = EX side driving p3_*, slave = the memory stage.
// There is no handshake: one bundle is accepted on every rising clock edge.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic                 p3_alu_regWrite;
   logic                 p3_mem_regWrite;
   logic                 p3_memRead;
   logic                 p3_memWrite;
   logic [REG_IDX_W-1:0] p3_alu_rd;
   logic [REG_IDX_W-1:0] p3_mem_rd;
   logic [BYTE_W-1:0]    p3_mem_reg_rd;
   logic [DATA_W-1:0]    p3_alu_aluOut;
   logic [DATA_W-1:0]    p3_mem_address;

   logic                 p4_alu_regWrite;
   logic                 p4_mem_regWrite;
   logic [REG_IDX_W-1:0] p4_alu_rd;
   logic [REG_IDX_W-1:0] p4_mem_rd;
   logic [DATA_W-1:0]    p4_alu_result;
   logic [DATA_W-1:0]    p4_mem_result;
   logic                 mem_fault;

   modport master (
      output p3_alu_regWrite, p3_mem_regWrite, p3_memRead, p3_memWrite,
             p3_alu_rd, p3_mem_rd, p3_mem_reg_rd, p3_alu_aluOut, p3_mem_address,
      input  p4_alu_regWrite, p4_mem_regWrite, p4_alu_rd, p4_mem_rd,
             p4_alu_result, p4_mem_result, mem_fault
   );

   modport slave (
      input  p3_alu_regWrite, p3_mem_regWrite, p3_memRead, p3_memWrite,
             p3_alu_rd, p3_mem_rd, p3_mem_reg_rd, p3_alu_aluOut, p3_mem_address,
      output p4_alu_regWrite, p4_mem_regWrite, p4_alu_rd, p4_mem_rd,
             p4_alu_result, p4_mem_result, mem_fault
   );
endinterface : mem_stage_if

// File: rtl/mem_stage_dmem_byte_sp.sv
// dmem_byte_sp: single-port synchronous byte RAM. The read port always
// returns the byte held before any write at the same edge (read-before-write).
// Contents are not reset.
module dmem_byte_sp
   import mem_stage_pkg::*;
#(
   parameter int ADDR_BITS = DEF_DMEM_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [BYTE_W-1:0]    wdata,
   output logic [BYTE_W-1:0]    rdata
);

   logic [BYTE_W-1:0] mem [2**ADDR_BITS];

   // Write on enable; registered read sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule : dmem_byte_sp

// File: rtl/mem_stage.sv
// mem_stage: VLIW memory stage. Performs the MEM-slot byte load/store against
// a private data memory and registers both slot results into MEM/WB; the p4_*
// values double as the write-back forwarding sources.
// Optional feature macro: DMEM_RANGE_CHECK_EN (out-of-range accesses are
// suppressed and raise a sticky mem_fault; otherwise the address wraps).
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DMEM_ADDR_BITS = DEF_DMEM_ADDR_BITS
) (
   input  logic        clk,
   input  logic        reset,
   mem_stage_if.slave  bus
);

   logic [DMEM_ADDR_BITS-1:0] addr;
   logic                      out_of_range;
   logic                      ram_we;
   logic                      load_ok;
   logic [BYTE_W-1:0]         ram_rdata;

   logic                      alu_regwrite_q;
   logic                      mem_regwrite_q;
   logic [REG_IDX_W-1:0]      alu_rd_q;
   logic [REG_IDX_W-1:0]      mem_rd_q;
   logic [DATA_W-1:0]         alu_result_q;
   logic                      load_q;

   assign addr = bus.p3_mem_address[DMEM_ADDR_BITS-1:0];

`ifdef DMEM_RANGE_CHECK_EN
   assign out_of_range = |bus.p3_mem_address[DATA_W-1:DMEM_ADDR_BITS];
`else
   assign out_of_range = 1'b0;
`endif

   // A store in a reset cycle or outside the memory never touches the RAM.
   assign ram_we  = bus.p3_memWrite & ~reset & ~out_of_range;
   assign load_ok = bus.p3_memRead & ~out_of_range;

   dmem_byte_sp #(
      .ADDR_BITS (DMEM_ADDR_BITS)
   ) u_dmem (
      .clk   (clk),
      .we    (ram_we),
      .addr  (addr),
      .wdata (bus.p3_mem_reg_rd),
      .rdata (ram_rdata)
   );

   // MEM/WB pipeline register; load_q qualifies the RAM's registered read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_regwrite_q <= 1'b0;
         mem_regwrite_q <= 1'b0;
         alu_rd_q       <= '0;
         mem_rd_q       <= '0;
         alu_result_q   <= '0;
         load_q         <= 1'b0;
      end else begin
         alu_regwrite_q <= bus.p3_alu_regWrite;
         mem_regwrite_q <= bus.p3_mem_regWrite;
         alu_rd_q       <= bus.p3_alu_rd;
         mem_rd_q       <= bus.p3_mem_rd;
         alu_result_q   <= bus.p3_alu_aluOut;
         load_q         <= load_ok;
      end
   end

   assign bus.p4_alu_regWrite = alu_regwrite_q;
   assign bus.p4_mem_regWrite = mem_regwrite_q;
   assign bus.p4_alu_rd       = alu_rd_q;
   assign bus.p4_mem_rd       = mem_rd_q;
   assign bus.p4_alu_result   = alu_result_q;
   assign bus.p4_mem_result   = load_q ? {{(DATA_W-BYTE_W){1'b0}}, ram_rdata} : '0;

`ifdef DMEM_RANGE_CHECK_EN
   logic fault_q;

   // Sticky fault: set by any out-of-range load or store, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_q <= 1'b0;
      end else if (out_of_range && (bus.p3_memRead || bus.p3_memWrite)) begin
         fault_q <= 1'b1;
      end
   end

   assign bus.mem_fault = fault_q;
`else
   assign bus.mem_fault = 1'b0;
`endif

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table-driven bench for mem_stage plus hand-written
// sequences for address wrap / range checking and reset-suppressed stores.
module tb_mem_stage;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mem_stage_if bus ();

   mem_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Clock: 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        alu_rw;
      logic        mem_rw;
      logic        rd_en;
      logic        wr_en;
      logic [2:0]  alu_rd;
      logic [2:0]  mem_rd;
      logic [7:0]  wdata;
      logic [31:0] alu_out;
      logic [31:0] addr;
      logic        e_alu_rw;
      logic        e_mem_rw;
      logic [2:0]  e_alu_rd;
      logic [2:0]  e_mem_rd;
      logic [31:0] e_alu_res;
      logic [31:0] e_mem_res;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one bundle, then advance past the next rising edge.
   task automatic drive(input logic alu_rw, input logic mem_rw, input logic rd_en,
                        input logic wr_en, input logic [2:0] alu_rd, input logic [2:0] mem_rd,
                        input logic [7:0] wdata, input logic [31:0] alu_out,
                        input logic [31:0] addr);
      bus.p3_alu_regWrite = alu_rw;
      bus.p3_mem_regWrite = mem_rw;
      bus.p3_memRead      = rd_en;
      bus.p3_memWrite     = wr_en;
      bus.p3_alu_rd       = alu_rd;
      bus.p3_mem_rd       = mem_rd;
      bus.p3_mem_reg_rd   = wdata;
      bus.p3_alu_aluOut   = alu_out;
      bus.p3_mem_address  = addr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 3'd0, 3'd0, 8'h00, 32'h0, 32'h0);
   endtask

   task automatic check_out(input string tag, input logic e_alu_rw, input logic e_mem_rw,
                            input logic [2:0] e_alu_rd, input logic [2:0] e_mem_rd,
                            input logic [31:0] e_alu_res, input logic [31:0] e_mem_res,
                            input logic e_fault);
      check({tag, ".alu_regWrite"}, {31'b0, bus.p4_alu_regWrite}, {31'b0, e_alu_rw});
      check({tag, ".mem_regWrite"}, {31'b0, bus.p4_mem_regWrite}, {31'b0, e_mem_rw});
      check({tag, ".alu_rd"},       {29'b0, bus.p4_alu_rd},       {29'b0, e_alu_rd});
      check({tag, ".mem_rd"},       {29'b0, bus.p4_mem_rd},       {29'b0, e_mem_rd});
      check({tag, ".alu_result"},   bus.p4_alu_result,            e_alu_res);
      check({tag, ".mem_result"},   bus.p4_mem_result,            e_mem_res);
      check({tag, ".mem_fault"},    {31'b0, bus.mem_fault},       {31'b0, e_fault});
   endtask

   initial begin
      checks = 0;
      errors = 0;

      //            alu mem rd wr ard mrd  wdata   alu_out        addr          | e_alu e_mem e_ard e_mrd e_alu_res     e_mem_res
      vecs[0]  = '{0, 0, 0, 1, 3'd0, 3'd0, 8'hA5, 32'h0,        32'h0000_0010, 0, 0, 3'd0, 3'd0, 32'h0,        32'h0};
      vecs[1]  = '{1, 1, 1, 0, 3'd5, 3'd3, 8'h00, 32'hDEADBEEF, 32'h0000_0010, 1, 1, 3'd5, 3'd3, 32'hDEADBEEF, 32'h0000_00A5};
      vecs[2]  = '{1, 0, 0, 1, 3'd1, 3'd0, 8'h12, 32'h0000_1234, 32'h0000_0030, 1, 0, 3'd1, 3'd0, 32'h0000_1234, 32'h0};
      vecs[3]  = '{0, 1, 1, 1, 3'd0, 3'd2, 8'h34, 32'h0,        32'h0000_0030, 0, 1, 3'd0, 3'd2, 32'h0,        32'h0000_0012};
      vecs[4]  = '{0, 1, 1, 0, 3'd0, 3'd7, 8'h00, 32'h0,        32'h0000_0030, 0, 1, 3'd0, 3'd7, 32'h0,        32'h0000_0034};
      vecs[5]  = '{0, 0, 0, 1, 3'd0, 3'd0, 8'h11, 32'h0,        32'h0000_0000, 0, 0, 3'd0, 3'd0, 32'h0,        32'h0};
      vecs[6]  = '{1, 1, 1, 0, 3'd6, 3'd1, 8'h00, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1, 3'd6, 3'd1, 32'hFFFF_FFFF, 32'h0000_0011};
      vecs[7]  = '{0, 0, 0, 1, 3'd0, 3'd0, 8'h5A, 32'h0,        32'h0000_0020, 0, 0, 3'd0, 3'd0, 32'h0,        32'h0};
      vecs[8]  = '{0, 0, 0, 1, 3'd0, 3'd0, 8'hC3, 32'h0,        32'h0000_00FF, 0, 0, 3'd0, 3'd0, 32'h0,        32'h0};
      vecs[9]  = '{0, 1, 1, 0, 3'd0, 3'd6, 8'h00, 32'h0,        32'h0000_00FF, 0, 1, 3'd0, 3'd6, 32'h0,        32'h0000_00C3};
      vecs[10] = '{1, 1, 0, 0, 3'd7, 3'd4, 8'h00, 32'h8000_0001, 32'h0000_0030, 1, 1, 3'd7, 3'd4, 32'h8000_0001, 32'h0};
      vecs[11] = '{0, 0, 1, 0, 3'd0, 3'd0, 8'h00, 32'h0,        32'h0000_0020, 0, 0, 3'd0, 3'd0, 32'h0,        32'h0000_005A};

      // Reset: two edges with an idle bundle, then check all outputs cleared.
      reset = 1'b1;
      idle();
      idle();
      check_out("reset", 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0);
      reset = 1'b0;

      // Table: one bundle per cycle, results visible right after the edge.
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].alu_rw, vecs[i].mem_rw, vecs[i].rd_en, vecs[i].wr_en,
               vecs[i].alu_rd, vecs[i].mem_rd, vecs[i].wdata, vecs[i].alu_out, vecs[i].addr);
         check_out($sformatf("vec%0d", i), vecs[i].e_alu_rw, vecs[i].e_mem_rw,
                   vecs[i].e_alu_rd, vecs[i].e_mem_rd, vecs[i].e_alu_res,
                   vecs[i].e_mem_res, 1'b0);
      end

`ifdef DMEM_RANGE_CHECK_EN
      // Out-of-range store is dropped and raises the sticky fault.
      drive(0, 0, 0, 1, 3'd0, 3'd0, 8'h77, 32'h0, 32'h0000_0100);
      check_out("oor_store", 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1);
      drive(0, 1, 1, 0, 3'd0, 3'd2, 8'h00, 32'h0, 32'h0000_0000);
      check_out("oor_after_load0", 0, 1, 3'd0, 3'd2, 32'h0, 32'h0000_0011, 1'b1);
      drive(0, 1, 1, 0, 3'd0, 3'd3, 8'h00, 32'h0, 32'h0000_0100);
      check_out("oor_load", 0, 1, 3'd0, 3'd3, 32'h0, 32'h0, 1'b1);
      idle();
      idle();
      check_out("fault_sticky", 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1);
`else
      // Upper address bits are ignored: 0x110 aliases 0x10.
      drive(0, 0, 0, 1, 3'd0, 3'd0, 8'h3C, 32'h0, 32'h0000_0110);
      check_out("wrap_store", 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0);
      drive(0, 1, 1, 0, 3'd0, 3'd3, 8'h00, 32'h0, 32'h0000_0010);
      check_out("wrap_load", 0, 1, 3'd0, 3'd3, 32'h0, 32'h0000_003C, 1'b0);
      drive(0, 1, 1, 0, 3'd0, 3'd4, 8'h00, 32'h0, 32'hFFFF_FF10);
      check_out("wrap_load_hi", 0, 1, 3'd0, 3'd4, 32'h0, 32'h0000_003C, 1'b0);
`endif

      // Reset coinciding with a store: outputs clear and memory keeps 0x5A.
      reset = 1'b1;
      drive(1, 1, 1, 1, 3'd5, 3'd5, 8'hFF, 32'hCAFE_F00D, 32'h0000_0020);
      check_out("reset_store", 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0);
      reset = 1'b0;
      drive(0, 1, 1, 0, 3'd0, 3'd1, 8'h00, 32'h0, 32'h0000_0020);
      check_out("post_reset_load", 0, 1, 3'd0, 3'd1, 32'h0, 32'h0000_005A, 1'b0);

      // Load with memRead=0 but previously loaded data in the RAM read port.
      drive(0, 0, 0, 0, 3'd0, 3'd0, 8'h00, 32'h0, 32'h0000_0020);
      check_out("no_read_zero", 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mem_stage

// File: doc/mem_stage.md
# mem_stage

VLIW memory stage sitting between the EX/MEM pipeline register and write-back. It performs the MEM-slot byte load or store against a private synchronous data memory and carries the ALU-slot result alongside. It registers both slot results into the MEM/WB pipeline register. The registered MEM/WB values also serve as the write-back forwarding sources for the EX-stage forwarding muxes.

## Interface
- DMEM_ADDR_BITS, 8: data memory address width; depth = 2**DMEM_ADDR_BITS bytes.
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- p3_alu_regWrite  in  1  ALU slot writes a register.
- p3_mem_regWrite  in  1  MEM slot writes a register (loads).
- p3_memRead  in  1  MEM slot is a byte load.
- p3_memWrite  in  1  MEM slot is a byte store.
- p3_alu_rd  in  3  ALU slot destination register.
- p3_mem_rd  in  3  MEM slot destination register.
- p3_mem_reg_rd  in  8  store data byte.
- p3_alu_aluOut  in  32  ALU slot result.
- p3_mem_address  in  32  byte address from the EX-stage adder.
- p4_alu_regWrite, p4_mem_regWrite  out  1 each  registered write enables.
- p4_alu_rd, p4_mem_rd  out  3 each  registered destination registers.
- p4_alu_result  out  32  registered ALU result; also forwarding source.
- p4_mem_result  out  32  registered load data, zero-extended byte; also forwarding source.
- mem_fault  out  1  sticky out-of-range access flag. Tied 0 unless DMEM_RANGE_CHECK_EN is defined.

## Operation
- ALU slot: p3_alu_regWrite, p3_alu_rd and p3_alu_aluOut pass unchanged into the MEM/WB register.
- Effective address = p3_mem_address[DMEM_ADDR_BITS-1:0]. Upper bits are ignored (wrap-around) unless range checking is enabled.
- Store (p3_memWrite=1): mem[addr] <= p3_mem_reg_rd at the clock edge.
- Load (p3_memRead=1): p4_mem_result <= {24'b0, mem[addr]} at the same edge. The memory is read-before-write.
- If p3_memRead=0, p4_mem_result <= 0.
- p3_memRead and p3_memWrite both 1 (illegal encoding, defined anyway): the store is performed, and the load returns the old byte.
- p4_mem_regWrite follows p3_mem_regWrite regardless of memRead. Decode guarantees consistency.
- p4_* are the only forwarding values exported. The EX stage selects them through its forwarding selectors.
- Memory contents are not affected by reset and are undefined after power-up.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on p4_* after edge N.
- Store at edge N followed by a load of the same address at edge N+1 returns the stored byte; no hazard logic is needed.
- A load at the same address and edge as a store cannot occur (single MEM slot), apart from the illegal-encoding case above.
- Reset at edge N:
  - all p4_* outputs <= 0 and mem_fault <= 0;
  - any store presented in that cycle is suppressed (memory unchanged);
  - outputs resume normal behaviour from edge N+1.
- No stalls or handshakes: the stage accepts one bundle every cycle.

## Configuration
- DMEM_RANGE_CHECK_EN defined:
  - any load or store with a nonzero bit in p3_mem_address[31:DMEM_ADDR_BITS] is out of range;
  - an out-of-range store is dropped;
  - an out-of-range load returns p4_mem_result = 0;
  - mem_fault is set at that edge and stays 1 until reset.
- DMEM_RANGE_CHECK_EN undefined: the address wraps and mem_fault is constant 0.

## Structure
- Shared package: REG_IDX_W=3, DATA_W=32, BYTE_W=8, and the default DMEM_ADDR_BITS.
- One sub-module, dmem_byte_sp: single-port synchronous byte RAM with read-before-write and a write enable, instantiated once.
- MEM/WB register and fault flag live in mem_stage.

## Test plan
- Store 0xA5 to address 0x10, then load 0x10 next cycle with mem_rd=3 -> p4_mem_result=0x000000A5, p4_mem_rd=3, p4_mem_regWrite=1 one cycle later.
- ALU bundle aluOut=0xDEADBEEF, alu_rd=5, regWrite=1 issued with a concurrent load -> both p4_alu_result and p4_mem_result update on the same edge.
- Without the macro, store 0x3C to 0x00000110 then load 0x10 -> 0x0000003C (wrap).
- With DMEM_RANGE_CHECK_EN:
  - store 0x77 to 0x100 -> dropped, mem_fault=1;
  - load 0x00 (prewritten 0x11) -> 0x00000011;
  - mem_fault stays 1 until reset.
- Assert reset in the same cycle as a store of 0xFF to 0x20 -> all p4_* = 0. A later load of 0x20 returns its prior value, not 0xFF.
- memRead=memWrite=1 at 0x30, old byte 0x12, new byte 0x34 -> p4_mem_result=0x00000012. A subsequent load returns 0x00000034.
